// File: rtl/adc128s_fc_model_pkg.sv
// Shared constants for the ADC128S-style SPI converter model: channel
// addresses, frame length and where the channel field sits in a command.
package adc128s_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;
  localparam int ADDR_MSB   = 13;
  localparam int ADDR_LSB   = 11;

  typedef logic [2:0] chan_t;

  localparam chan_t CH_LD_LFT  = 3'd0;
  localparam chan_t CH_LD_RGHT = 3'd4;
  localparam chan_t CH_STEER   = 3'd5;
  localparam chan_t CH_BATT    = 3'd6;

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

endpackage

// File: rtl/adc128s_fc_model_spi_sync_edge.sv
// Two-flop synchronizer with a third flop for edge detection; reset drives
// every stage to the line's idle level so no edge appears when reset lifts.
module spi_sync_edge #(
  parameter logic IDLE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {3{IDLE}};
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/adc128s_fc_model.sv
// SPI slave model of an 8-channel 12-bit ADC: each frame returns the
// channel addressed by the previous complete frame.
module adc128s_fc_model
  import adc128s_pkg::*;
#(
  parameter logic [11:0] UNUSED_VAL = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [1:0] mosi_q;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Only the low 14 received bits can ever reach the channel field.
  logic [ADDR_MSB:0]     rx_q, rx_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  chan_t                 ptr_q, ptr_d;
  logic                  act_q, act_d;
  logic [11:0]           sel_val;

  spi_sync_edge #(.IDLE(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.IDLE(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SS_n),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  always_comb begin
    case (ptr_q)
      CH_LD_LFT:  sel_val = ld_cell_lft;
      CH_LD_RGHT: sel_val = ld_cell_rght;
      CH_STEER:   sel_val = steerPot;
      CH_BATT:    sel_val = batt;
      default:    sel_val = UNUSED_VAL;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    rx_d  = rx_q;
    tx_d  = tx_q;
    ptr_d = ptr_q;
    act_d = act_q;
    if (ss_fall) begin
      act_d = 1'b1;
      cnt_d = '0;
      rx_d  = '0;
      tx_d  = {4'h0, sel_val};
    end else if (ss_rise) begin
      act_d = 1'b0;
      if (act_q && cnt_q == FRAME_CNT) begin
        ptr_d = rx_q[ADDR_MSB:ADDR_LSB];
      end
    end else if (act_q) begin
      if (sclk_rise && cnt_q != FRAME_CNT) begin
        rx_d  = {rx_q[ADDR_MSB-1:0], mosi_q[1]};
        cnt_d = cnt_q + 1'b1;
      end
      // The front-porch fall precedes any rise and must not shift.
      if (sclk_fall && cnt_q != '0) begin
        tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_q <= '0;
      cnt_q  <= '0;
      rx_q   <= '0;
      tx_q   <= '0;
      ptr_q  <= CH_LD_LFT;
      act_q  <= 1'b0;
    end else begin
      mosi_q <= {mosi_q[0], MOSI};
      cnt_q  <= cnt_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      ptr_q  <= ptr_d;
      act_q  <= act_d;
    end
  end

  assign MISO = SS_n ? 1'bz : tx_q[FRAME_BITS-1];

endmodule

// File: tb/tb_adc128s_fc_model.sv
// Bench for adc128s_fc_model: an SPI master drives frames, a reference model
// predicts each returned word, and a monitor compares completed frames.
module tb_adc128s_fc_model;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  wire         miso;
  logic [11:0] ld_cell_lft = '0;
  logic [11:0] ld_cell_rght = '0;
  logic [11:0] steerPot = '0;
  logic [11:0] batt = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mon_word = '0;
  int          mon_bits = 0;

  pullup (miso);

  always #5 clk = ~clk;

  adc128s_fc_model #(.UNUSED_VAL(12'h000)) dut (
    .clk          (clk),
    .rst          (rst),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (miso),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steerPot),
    .batt         (batt)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: channel map applied to the analog inputs at frame start.
  function automatic logic [11:0] ref_val(input int ch);
    case (ch)
      0:       return ld_cell_lft;
      4:       return ld_cell_rght;
      5:       return steerPot;
      6:       return batt;
      default: return 12'h000;
    endcase
  endfunction

  // act: 0 plain frame, 1 change batt mid-frame, 2 reset mid-frame.
  task automatic frame(input int ch, input int nbits, input int act);
    logic [15:0] cmd;
    cmd = {2'b00, 3'(ch), 11'($urandom)};
    if (nbits == 16 && act != 2) exp_q.push_back({4'h0, ref_val(model_ptr)});
    SS_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      wait_clk(6);
      SCLK = 1'b1;
      wait_clk(6);
      if (i == 7 && act == 1) batt = 12'h555;
    end
    if (act == 2) begin
      rst = 1'b1;
      wait_clk(2);
      SS_n = 1'b1;
      wait_clk(4);
      chk("rst_mid_idle", {15'd0, miso}, 16'd1);
      rst = 1'b0;
      model_ptr = 0;
      wait_clk(6);
    end else begin
      wait_clk(4);
      SS_n = 1'b1;
      wait_clk(6);
      if (nbits == 16) model_ptr = ch;
    end
  endtask

  // Monitor: shift in MISO at each SCLK rise within a frame.
  always @(negedge SS_n) begin
    mon_bits = 0;
    mon_word = '0;
  end

  always @(posedge SCLK) begin
    if (!SS_n) begin
      mon_word = {mon_word[14:0], miso};
      mon_bits++;
    end
  end

  always @(posedge SS_n) begin
    if (mon_bits == 16) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_unexpected: got %h expected none", mon_word);
      end else begin
        chk("frame_data", mon_word, exp_q.pop_front());
      end
    end
    mon_bits = 0;
  end

  initial begin
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    chk("reset_idle_miso", {15'd0, miso}, 16'd1);

    // Reset read: first frame returns channel 0.
    ld_cell_lft = 12'h2AB;
    frame(4, 16, 0);

    // Channel sweep.
    ld_cell_rght = 12'h123;
    steerPot     = 12'h800;
    batt         = 12'hFFF;
    frame(5, 16, 0);
    frame(6, 16, 0);
    frame(1, 16, 0);
    frame(0, 16, 0);

    // Capture instant: batt changes mid-frame while channel 6 is selected.
    batt = 12'hA00;
    frame(6, 16, 0);
    frame(6, 16, 1);
    frame(0, 16, 0);

    // Aborted frame leaves the pointer alone.
    frame(4, 16, 0);
    frame(5, 9, 0);
    frame(0, 16, 0);

    // Reset mid-frame.
    frame(6, 16, 0);
    frame(5, 8, 2);
    frame(4, 16, 0);

    // Idle MISO under SCLK activity with SS_n high.
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b0;
      MOSI = 1'($urandom);
      wait_clk(3);
      chk("idle_miso_lo", {15'd0, miso}, 16'd1);
      SCLK = 1'b1;
      wait_clk(3);
      chk("idle_miso_hi", {15'd0, miso}, 16'd1);
    end
    wait_clk(6);
    frame(6, 16, 0);

    // Randomized frames, occasionally aborted.
    for (int n = 0; n < 40; n++) begin
      ld_cell_lft  = 12'($urandom);
      ld_cell_rght = 12'($urandom);
      steerPot     = 12'($urandom);
      batt         = 12'($urandom);
      frame($urandom_range(0, 7),
            ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 16, 0);
    end

    wait_clk(10);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
